fp_cmp_arbiter: RTL and testbench
=================================

Name: fp_cmp_arbiter

Overview:
- Shares one combinational FP compare datapath (FEQ/FLT/FLE) between two requesters: r0 (main FPU issue path) and r1 (secondary path, e.g. FMIN/FMAX pre-compare or debug).
- Round-robin arbitration on valid/ready inputs; registered single-entry output slot with valid/ready; sticky accumulation of the NV (invalid) flag for the fflags CSR.
- Sits between the FP issue logic and the integer writeback / CSR flag update.

Parameters:
- FLEN, 32, operand width: 32 (single) or 64 (double); passed to the compare sub-module.
- TAG_W, 5, width of the opaque requester tag (destination rd) carried with each operation.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_a  in  FLEN  rs1 operand
- r0_b  in  FLEN  rs2 operand
- r0_op  in  2  00 FEQ, 01 FLT, 10 FLE, 11 reserved
- r0_tag  in  TAG_W  destination tag
- r1_valid / r1_ready / r1_a / r1_b / r1_op / r1_tag: same as r0 for requester 1
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes the result
- out_result  out  32  0 or 1, zero-extended
- out_nv  out  1  NV flag for this result
- out_src  out  1  requester index of this result
- out_tag  out  TAG_W  tag of this result
- flags_clr  in  1  clear the sticky NV flag
- nv_sticky  out  1  OR of out_nv over all accepted operations since reset/clear

Behaviour:
- Reset: applied on rising clk while reset_n=0. Clears out_valid, out_result, out_nv, out_src, out_tag and nv_sticky to 0. Sets the RR pointer so r0 has priority. Reset mid-operation drops the slot contents with no replay.
- FSM (2 states):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - Transitions: EMPTY->FULL on accept. FULL->EMPTY on drain (out_ready=1) without accept. FULL->FULL on drain+accept in the same cycle (full throughput, 1 op/cycle). FULL with out_ready=0 holds: all out_* stable, no accept.
- can_accept = EMPTY or (FULL and out_ready).
- Arbitration, combinational:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - rX_ready = can_accept and grant==X. Never both high.
  - The RR pointer updates only on an accepted transfer (valid&ready).
  - rX_ready may depend on the other requester's valid. Requesters must hold inputs stable while valid and not ready; they must not wait for ready before asserting valid.
- Latency: accepted in cycle N; out_valid and the result are visible in cycle N+1.
- Datapath: mux the granted a/b/op into the compare sub-module. Register its result and nv together with the granted tag and src.
- Compare semantics (sub-module):
  - Any NaN gives result 0.
  - FEQ raises NV only on a signalling NaN; FLT/FLE raise NV on any NaN.
  - +0 equals -0.
  - op 11: result 0, nv 0, accepted normally.
- nv_sticky next value = (flags_clr ? 0 : nv_sticky) | (accept & cmp_nv). A same-cycle clear and new NV leaves it set. The NV is folded in at accept, so it is visible the same cycle as out_valid.
- No reordering: each requester sees results in its own issue order.

Decomposition:
- Shared package: opcode constants CMP_FEQ=2'b00, CMP_FLT=2'b01, CMP_FLE=2'b10; state encodings S_EMPTY/S_FULL.
- One sub-module instance: the existing fp_compare combinational unit, with FLEN passed through.
- Arbiter, output slot and sticky flag stay in this module.

Test Plan:
- r0 FEQ a=b=0x3F800000 (1.0), out_ready=1 -> next cycle out_valid=1, result=1, nv=0, src=0, tag echoed.
- r1 FLT a=0x7F800001 (sNaN), b=0x3F800000 -> result=0, nv=1, nv_sticky=1 on the same cycle as out_valid. Then r0 FEQ with qNaN 0x7FC00000 -> nv=0 and sticky stays 1.
- Both valid for 6 cycles, out_ready=1 -> grants r0,r1,r0,r1,r0,r1; one result per cycle; out_src alternates.
- Slot FULL, out_ready=0 for 3 cycles with both valid -> r0_ready=r1_ready=0, out_* unchanged. Raise out_ready -> drain and accept in the same cycle, no bubble.
- flags_clr=1 in the same cycle an sNaN FLE is accepted -> nv_sticky=1. Next cycle flags_clr=1 with no op -> nv_sticky=0.
- reset_n=0 for one cycle while FULL with out_ready=0 -> out_valid=0 afterward and nv_sticky=0. Next simultaneous request grants r0 first.

Source files
------------

// File: rtl/fp_cmp_arbiter_pkg.sv
// rtl/fp_cmp_arbiter_pkg.sv - shared opcodes and slot states for the FP compare arbiter
package fp_cmp_arbiter_pkg;

  localparam logic [1:0] CMP_FEQ = 2'b00;
  localparam logic [1:0] CMP_FLT = 2'b01;
  localparam logic [1:0] CMP_FLE = 2'b10;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/fp_cmp_arbiter_if.sv
// rtl/fp_cmp_arbiter_if.sv - request and result handshake bundles for the FP compare arbiter
interface fp_cmp_req_if #(
  parameter int FLEN  = 32,
  parameter int TAG_W = 5
);
  logic             valid;
  logic             ready;
  logic [FLEN-1:0]  a;
  logic [FLEN-1:0]  b;
  logic [1:0]       op;
  logic [TAG_W-1:0] tag;

  modport master (output valid, a, b, op, tag, input ready);
  modport slave  (input valid, a, b, op, tag, output ready);
endinterface

interface fp_cmp_rsp_if #(
  parameter int TAG_W = 5
);
  logic             valid;
  logic             ready;
  logic [31:0]      result;
  logic             nv;
  logic             src;
  logic [TAG_W-1:0] tag;

  modport master (output valid, result, nv, src, tag, input ready);
  modport slave  (input valid, result, nv, src, tag, output ready);
endinterface

// File: rtl/fp_cmp_arbiter_compare.sv
// rtl/fp_cmp_arbiter_compare.sv - combinational IEEE-754 FEQ/FLT/FLE compare with NV flag
module fp_compare
  import fp_cmp_arbiter_pkg::*;
#(
  parameter int FLEN = 32
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [1:0]      op,
  output logic            result,
  output logic            nv
);

  localparam int EXP_W = (FLEN == 64) ? 11 : 8;
  localparam int MAN_W = FLEN - 1 - EXP_W;

  logic            sign_a, sign_b;
  logic [FLEN-2:0] mag_a, mag_b;
  logic            nan_a, nan_b, snan_a, snan_b, any_nan, any_snan;
  logic            both_zero, eq, lt;

  assign sign_a = a[FLEN-1];
  assign sign_b = b[FLEN-1];
  assign mag_a  = a[FLEN-2:0];
  assign mag_b  = b[FLEN-2:0];

  // Quiet bit is the mantissa MSB; a NaN with it clear is signalling.
  assign nan_a  = (&a[FLEN-2 -: EXP_W]) && (|a[MAN_W-1:0]);
  assign nan_b  = (&b[FLEN-2 -: EXP_W]) && (|b[MAN_W-1:0]);
  assign snan_a = nan_a && !a[MAN_W-1];
  assign snan_b = nan_b && !b[MAN_W-1];
  assign any_nan  = nan_a || nan_b;
  assign any_snan = snan_a || snan_b;

  assign both_zero = (mag_a == '0) && (mag_b == '0);
  assign eq        = (a == b) || both_zero;

  always_comb begin
    lt = 1'b0;
    case ({sign_a, sign_b})
      2'b00:   lt = mag_a < mag_b;
      2'b11:   lt = mag_a > mag_b;
      2'b10:   lt = !both_zero;
      default: lt = 1'b0;
    endcase
  end

  always_comb begin
    result = 1'b0;
    nv     = 1'b0;
    case (op)
      CMP_FEQ: begin
        result = !any_nan && eq;
        nv     = any_snan;
      end
      CMP_FLT: begin
        result = !any_nan && lt;
        nv     = any_nan;
      end
      CMP_FLE: begin
        result = !any_nan && (lt || eq);
        nv     = any_nan;
      end
      default: begin
        result = 1'b0;
        nv     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// rtl/fp_cmp_arbiter.sv - round-robin sharing of one FP compare unit between two requesters
module fp_cmp_arbiter
  import fp_cmp_arbiter_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  fp_cmp_req_if.slave   r0,
  fp_cmp_req_if.slave   r1,
  fp_cmp_rsp_if.master  out,
  input  logic          flags_clr,
  output logic          nv_sticky
);

  slot_state_e      state, state_nxt;
  logic             last_grant;
  logic             grant;
  logic             can_accept;
  logic             accept;

  logic [FLEN-1:0]  sel_a, sel_b;
  logic [1:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic             cmp_result, cmp_nv;

  logic             res_q, nv_q, src_q;
  logic [TAG_W-1:0] tag_q;

  assign can_accept = (state == S_EMPTY) || out.ready;

  // Contention goes to whoever did not win the last accepted transfer.
  always_comb begin
    grant = 1'b0;
    if (r0.valid && r1.valid) begin
      grant = ~last_grant;
    end else if (r1.valid) begin
      grant = 1'b1;
    end
  end

  assign r0.ready = can_accept && !grant;
  assign r1.ready = can_accept && grant;
  assign accept   = can_accept && (grant ? r1.valid : r0.valid);

  assign sel_a   = grant ? r1.a   : r0.a;
  assign sel_b   = grant ? r1.b   : r0.b;
  assign sel_op  = grant ? r1.op  : r0.op;
  assign sel_tag = grant ? r1.tag : r0.tag;

  fp_compare #(
    .FLEN (FLEN)
  ) u_cmp (
    .a      (sel_a),
    .b      (sel_b),
    .op     (sel_op),
    .result (cmp_result),
    .nv     (cmp_nv)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (accept) state_nxt = S_FULL;
      S_FULL:  if (out.ready && !accept) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_EMPTY;
      last_grant <= 1'b1;
      res_q      <= 1'b0;
      nv_q       <= 1'b0;
      src_q      <= 1'b0;
      tag_q      <= '0;
      nv_sticky  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        res_q      <= cmp_result;
        nv_q       <= cmp_nv;
        src_q      <= grant;
        tag_q      <= sel_tag;
      end
      // A clear and a new NV in the same cycle leave the flag set.
      nv_sticky <= (flags_clr ? 1'b0 : nv_sticky) | (accept & cmp_nv);
    end
  end

  assign out.valid  = (state == S_FULL);
  assign out.result = {31'b0, res_q};
  assign out.nv     = nv_q;
  assign out.src    = src_q;
  assign out.tag    = tag_q;

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// tb/tb_fp_cmp_arbiter.sv - scoreboard bench for the FP compare arbiter
module tb_fp_cmp_arbiter;
  import fp_cmp_arbiter_pkg::*;

  localparam int FLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] NEG1 = 32'hBF800000;
  localparam logic [31:0] PZ   = 32'h00000000;
  localparam logic [31:0] NZ   = 32'h80000000;
  localparam logic [31:0] SNAN = 32'h7F800001;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic             res;
    logic             nv;
  } exp_t;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic             res;
    logic             nv;
  } req_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flags_clr;
  logic nv_sticky;

  fp_cmp_req_if #(.FLEN(FLEN), .TAG_W(TAG_W)) r0_if ();
  fp_cmp_req_if #(.FLEN(FLEN), .TAG_W(TAG_W)) r1_if ();
  fp_cmp_rsp_if #(.TAG_W(TAG_W))              out_if ();

  fp_cmp_arbiter #(.FLEN(FLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .r0        (r0_if),
    .r1        (r1_if),
    .out       (out_if),
    .flags_clr (flags_clr),
    .nv_sticky (nv_sticky)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t got;
  req_t r0tab[4];
  req_t r1tab[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic src, input logic [TAG_W-1:0] tag, input logic res, input logic nv);
    exp_t e;
    e.src = src; e.tag = tag; e.res = res; e.nv = nv;
    sb.push_back(e);
  endtask

  task automatic drv0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [TAG_W-1:0] tag);
    r0_if.valid = v; r0_if.a = a; r0_if.b = b; r0_if.op = op; r0_if.tag = tag;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [TAG_W-1:0] tag);
    r1_if.valid = v; r1_if.a = a; r1_if.b = b; r1_if.op = op; r1_if.tag = tag;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  // Every handshaken result is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got tag %0d expected no result", out_if.tag);
      end else begin
        got = sb.pop_front();
        chk("out_result", out_if.result, {31'b0, got.res});
        chk("out_nv",     {31'b0, out_if.nv},  {31'b0, got.nv});
        chk("out_src",    {31'b0, out_if.src}, {31'b0, got.src});
        chk("out_tag",    {27'b0, out_if.tag}, {27'b0, got.tag});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    r0tab[0] = '{NEG1, ONE,  CMP_FLT, 5'd16, 1'b1, 1'b0};
    r0tab[1] = '{PZ,   NZ,   CMP_FLE, 5'd17, 1'b1, 1'b0};
    r0tab[2] = '{TWO,  ONE,  CMP_FEQ, 5'd18, 1'b0, 1'b0};
    r0tab[3] = '{ONE,  ONE,  CMP_FEQ, 5'd19, 1'b1, 1'b0};
    r1tab[0] = '{ONE,  NEG1, CMP_FLT, 5'd20, 1'b0, 1'b0};
    r1tab[1] = '{NZ,   PZ,   CMP_FEQ, 5'd21, 1'b1, 1'b0};
    r1tab[2] = '{QNAN, ONE,  2'b11,   5'd22, 1'b0, 1'b0};

    reset_n = 1'b0; flags_clr = 1'b0; out_if.ready = 1'b0;
    drv0(1'b0, '0, '0, CMP_FEQ, '0);
    drv1(1'b0, '0, '0, CMP_FEQ, '0);
    nxt; nxt;
    mid;
    chk("reset_out_valid",  {31'b0, out_if.valid}, 32'd0);
    chk("reset_out_result", out_if.result, 32'd0);
    chk("reset_out_tag",    {27'b0, out_if.tag}, 32'd0);
    chk("reset_nv_sticky",  {31'b0, nv_sticky}, 32'd0);
    nxt;
    reset_n = 1'b1;
    out_if.ready = 1'b1;

    // Single FEQ from r0
    drv0(1'b1, ONE, ONE, CMP_FEQ, 5'd3); push(1'b0, 5'd3, 1'b1, 1'b0);
    mid;
    chk("feq_r0_ready", {31'b0, r0_if.ready}, 32'd1);
    chk("feq_r1_ready", {31'b0, r1_if.ready}, 32'd0);
    nxt;
    drv0(1'b0, '0, '0, CMP_FEQ, '0);
    mid;
    chk("feq_out_valid", {31'b0, out_if.valid}, 32'd1);
    nxt;

    // sNaN FLT on r1, then quiet-NaN FEQ on r0
    drv1(1'b1, SNAN, ONE, CMP_FLT, 5'd7); push(1'b1, 5'd7, 1'b0, 1'b1);
    mid;
    chk("snan_r1_ready", {31'b0, r1_if.ready}, 32'd1);
    nxt;
    drv1(1'b0, '0, '0, CMP_FEQ, '0);
    drv0(1'b1, QNAN, ONE, CMP_FEQ, 5'd9); push(1'b0, 5'd9, 1'b0, 1'b0);
    mid;
    chk("sticky_with_out_valid", {31'b0, nv_sticky}, 32'd1);
    nxt;
    drv0(1'b0, '0, '0, CMP_FEQ, '0);
    drv1(1'b1, ONE, TWO, CMP_FLE, 5'd11); push(1'b1, 5'd11, 1'b1, 1'b0);
    mid;
    chk("sticky_after_qnan_feq", {31'b0, nv_sticky}, 32'd1);
    nxt;
    drv1(1'b0, '0, '0, CMP_FEQ, '0);

    // Both requesters valid for six cycles: strict alternation from r0
    begin
      int i0 = 0;
      int i1 = 0;
      for (int i = 0; i < 6; i++) begin
        drv0(1'b1, r0tab[i0].a, r0tab[i0].b, r0tab[i0].op, r0tab[i0].tag);
        drv1(1'b1, r1tab[i1].a, r1tab[i1].b, r1tab[i1].op, r1tab[i1].tag);
        if (i % 2 == 0) push(1'b0, r0tab[i0].tag, r0tab[i0].res, r0tab[i0].nv);
        else            push(1'b1, r1tab[i1].tag, r1tab[i1].res, r1tab[i1].nv);
        mid;
        chk("rr_r0_ready", {31'b0, r0_if.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
        chk("rr_r1_ready", {31'b0, r1_if.ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
        nxt;
        if (i % 2 == 0) i0++;
        else            i1++;
      end
      drv1(1'b0, '0, '0, CMP_FEQ, '0);
      drv0(1'b1, r0tab[3].a, r0tab[3].b, r0tab[3].op, r0tab[3].tag);
      push(1'b0, r0tab[3].tag, r0tab[3].res, r0tab[3].nv);
      nxt;
      drv0(1'b0, '0, '0, CMP_FEQ, '0);
      nxt;
    end

    // Stall with a full slot, then drain and accept with no bubble
    out_if.ready = 1'b0;
    drv0(1'b1, ONE, TWO, CMP_FLT, 5'd1); push(1'b0, 5'd1, 1'b1, 1'b0);
    mid;
    chk("stall_fill_r0_ready", {31'b0, r0_if.ready}, 32'd1);
    nxt;
    drv0(1'b1, ONE, ONE, CMP_FEQ, 5'd2);
    drv1(1'b1, TWO, ONE, CMP_FLE, 5'd4);
    for (int i = 0; i < 3; i++) begin
      mid;
      chk("stall_r0_ready",   {31'b0, r0_if.ready}, 32'd0);
      chk("stall_r1_ready",   {31'b0, r1_if.ready}, 32'd0);
      chk("stall_out_valid",  {31'b0, out_if.valid}, 32'd1);
      chk("stall_out_tag",    {27'b0, out_if.tag}, 32'd1);
      chk("stall_out_result", out_if.result, 32'd1);
      nxt;
    end
    out_if.ready = 1'b1;
    push(1'b1, 5'd4, 1'b0, 1'b0);
    mid;
    chk("unstall_r1_ready", {31'b0, r1_if.ready}, 32'd1);
    chk("unstall_r0_ready", {31'b0, r0_if.ready}, 32'd0);
    nxt;
    drv1(1'b0, '0, '0, CMP_FEQ, '0);
    push(1'b0, 5'd2, 1'b1, 1'b0);
    mid;
    chk("nobubble_out_valid", {31'b0, out_if.valid}, 32'd1);
    chk("nobubble_r0_ready",  {31'b0, r0_if.ready}, 32'd1);
    nxt;
    drv0(1'b0, '0, '0, CMP_FEQ, '0);
    nxt;

    // Clear coinciding with a new NV keeps the flag; a lone clear drops it
    flags_clr = 1'b1;
    drv0(1'b1, SNAN, ONE, CMP_FLE, 5'd5); push(1'b0, 5'd5, 1'b0, 1'b1);
    nxt;
    drv0(1'b0, '0, '0, CMP_FEQ, '0);
    mid;
    chk("sticky_clr_and_set", {31'b0, nv_sticky}, 32'd1);
    nxt;
    flags_clr = 1'b0;
    mid;
    chk("sticky_cleared", {31'b0, nv_sticky}, 32'd0);
    nxt;

    // Reset while full drops the slot and restores r0 priority
    out_if.ready = 1'b0;
    drv0(1'b1, SNAN, ONE, CMP_FLT, 5'd6);
    nxt;
    drv0(1'b0, '0, '0, CMP_FEQ, '0);
    reset_n = 1'b0;
    mid;
    chk("prereset_out_valid", {31'b0, out_if.valid}, 32'd1);
    chk("prereset_sticky",    {31'b0, nv_sticky}, 32'd1);
    nxt;
    reset_n = 1'b1;
    mid;
    chk("postreset_out_valid", {31'b0, out_if.valid}, 32'd0);
    chk("postreset_sticky",    {31'b0, nv_sticky}, 32'd0);
    nxt;
    out_if.ready = 1'b1;
    drv0(1'b1, ONE, ONE, CMP_FEQ, 5'd8);
    drv1(1'b1, ONE, ONE, CMP_FEQ, 5'd9);
    push(1'b0, 5'd8, 1'b1, 1'b0);
    mid;
    chk("postreset_r0_ready", {31'b0, r0_if.ready}, 32'd1);
    chk("postreset_r1_ready", {31'b0, r1_if.ready}, 32'd0);
    nxt;
    drv0(1'b0, '0, '0, CMP_FEQ, '0);
    push(1'b1, 5'd9, 1'b1, 1'b0);
    mid;
    chk("postreset_r1_next", {31'b0, r1_if.ready}, 32'd1);
    nxt;
    drv1(1'b0, '0, '0, CMP_FEQ, '0);
    nxt; nxt; nxt;

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
